// File: rtl/vga_gain_seq.sv
// Multi-channel VGA gain stepper: walks each channel's current gain toward its
// target one LSB per timed up/down pulse, with a free-running step phase and a manual override.
module vga_gain_seq #(
   parameter int NCH          = 8,
   parameter int GAIN_W       = 6,
   parameter int MAX_GAIN     = 63,
   parameter int DIV          = 4,
   parameter int PULSE_TICKS  = 2,
   parameter int SETTLE_TICKS = 1
) (
   input  logic                    clk_1M,
   input  logic                    rst,
   input  logic                    tgt_wr,
   input  logic [$clog2(NCH)-1:0]  tgt_ch,
   input  logic [GAIN_W-1:0]       tgt_gain,
   output logic [GAIN_W-1:0]       rd_gain,
   input  logic                    man_en,
   input  logic [NCH-1:0]          man_up,
   input  logic [NCH-1:0]          man_down,
   output logic [NCH-1:0]          up,
   output logic [NCH-1:0]          down,
   output logic [1:0]              step,
   output logic                    busy,
   output logic                    done
);

   localparam int CH_W  = $clog2(NCH);
   localparam int TC_W  = $clog2(DIV);
   localparam int MAXT  = (PULSE_TICKS > SETTLE_TICKS) ? PULSE_TICKS : SETTLE_TICKS;
   localparam int SUB_W = $clog2(MAXT + 1);

   typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;

   state_t             state_q, state_d;
   logic [TC_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [1:0]         step_q, step_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [CH_W-1:0]    ptr_q, ptr_d;
   logic               dir_q, dir_d;
   logic [NCH-1:0]     up_q, up_d;
   logic [NCH-1:0]     down_q, down_d;
   logic               done_q, done_d;
   logic [GAIN_W-1:0]  rd_q, rd_d;
   logic [GAIN_W-1:0]  cur_q [NCH];
   logic [GAIN_W-1:0]  cur_d [NCH];
   logic [GAIN_W-1:0]  tgt_q [NCH];
   logic [GAIN_W-1:0]  tgt_d [NCH];

   logic               tick;
   logic               cur_upd;
   logic [NCH-1:0]     neq;
   logic [GAIN_W-1:0]  tgt_wdata;
   logic               found;
   logic [CH_W-1:0]    sel_ch;
   logic               sel_dir;
   logic [NCH-1:0]     sel_onehot;

   assign tick = (tick_cnt_q == TC_W'(DIV - 1));

   generate
      if (MAX_GAIN < (2**GAIN_W) - 1) begin : g_clamp
         assign tgt_wdata = (tgt_gain > GAIN_W'(MAX_GAIN)) ? GAIN_W'(MAX_GAIN) : tgt_gain;
      end else begin : g_noclamp
         assign tgt_wdata = tgt_gain;
      end
   endgenerate

   // Per-channel gain registers; only the serviced channel ever moves, and only at pulse end.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign neq[gi]   = (cur_q[gi] != tgt_q[gi]);
         assign tgt_d[gi] = (tgt_wr && tgt_ch == CH_W'(gi)) ? tgt_wdata : tgt_q[gi];
         assign cur_d[gi] = (cur_upd && ch_q == CH_W'(gi))
                          ? (dir_q ? cur_q[gi] + 1'b1 : cur_q[gi] - 1'b1)
                          : cur_q[gi];
      end
   endgenerate

   // Round-robin search beginning just after the last serviced channel.
   always_comb begin
      found  = 1'b0;
      sel_ch = '0;
      for (int k = 1; k <= NCH; k++) begin
         if (!found && neq[CH_W'((int'(ptr_q) + k) % NCH)]) begin
            found  = 1'b1;
            sel_ch = CH_W'((int'(ptr_q) + k) % NCH);
         end
      end
   end

   assign sel_dir    = (tgt_q[sel_ch] > cur_q[sel_ch]);
   assign sel_onehot = NCH'(1) << sel_ch;

   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (tgt_ch == CH_W'(i)) rd_d = cur_q[i];
      end
   end

   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   assign step_d     = tick ? step_q + 2'd1 : step_q;

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      dir_d   = dir_q;
      up_d    = '0;
      down_d  = '0;
      done_d  = 1'b0;
      cur_upd = 1'b0;
      case (state_q)
         IDLE: begin
            if (man_en) begin
               up_d   = man_up & ~man_down;
               down_d = man_down & ~man_up;
            end else if (tick && found) begin
               state_d = PULSE;
               sub_d   = '0;
               ch_d    = sel_ch;
               ptr_d   = sel_ch;
               dir_d   = sel_dir;
               if (sel_dir) up_d = sel_onehot;
               else         down_d = sel_onehot;
            end
         end
         PULSE: begin
            up_d   = up_q;
            down_d = down_q;
            if (tick) begin
               if (sub_q == SUB_W'(PULSE_TICKS - 1)) begin
                  up_d    = '0;
                  down_d  = '0;
                  cur_upd = 1'b1;
                  sub_d   = '0;
                  state_d = SETTLE;
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
         end
         SETTLE: begin
            if (tick) begin
               if (sub_q == SUB_W'(SETTLE_TICKS - 1)) begin
                  state_d = IDLE;
                  done_d  = ~neq[ch_q];
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_1M) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         step_q     <= '0;
         sub_q      <= '0;
         ch_q       <= '0;
         ptr_q      <= CH_W'(NCH - 1);
         dir_q      <= 1'b0;
         up_q       <= '0;
         down_q     <= '0;
         done_q     <= 1'b0;
         rd_q       <= '0;
         for (int i = 0; i < NCH; i++) begin
            cur_q[i] <= '0;
            tgt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         step_q     <= step_d;
         sub_q      <= sub_d;
         ch_q       <= ch_d;
         ptr_q      <= ptr_d;
         dir_q      <= dir_d;
         up_q       <= up_d;
         down_q     <= down_d;
         done_q     <= done_d;
         rd_q       <= rd_d;
         for (int i = 0; i < NCH; i++) begin
            cur_q[i] <= cur_d[i];
            tgt_q[i] <= tgt_d[i];
         end
      end
   end

   assign up      = up_q;
   assign down    = down_q;
   assign step    = step_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign rd_gain = rd_q;

endmodule

// File: tb/tb_vga_gain_seq.sv
// Bench for vga_gain_seq: timeline reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_vga_gain_seq;

   localparam int NCH = 4;
   localparam int GW  = 4;
   localparam int MAXG = 5;
   localparam int DIV = 4;
   localparam int PT  = 2;
   localparam int ST  = 1;

   logic            clk_1M = 1'b0;
   logic            rst, tgt_wr, man_en;
   logic [1:0]      tgt_ch;
   logic [GW-1:0]   tgt_gain, rd_gain;
   logic [NCH-1:0]  man_up, man_down, up, down;
   logic [1:0]      step;
   logic            busy, done;

   always #5 clk_1M = ~clk_1M;

   vga_gain_seq #(
      .NCH(NCH), .GAIN_W(GW), .MAX_GAIN(MAXG), .DIV(DIV),
      .PULSE_TICKS(PT), .SETTLE_TICKS(ST)
   ) dut (
      .clk_1M(clk_1M), .rst(rst), .tgt_wr(tgt_wr), .tgt_ch(tgt_ch),
      .tgt_gain(tgt_gain), .rd_gain(rd_gain), .man_en(man_en),
      .man_up(man_up), .man_down(man_down), .up(up), .down(down),
      .step(step), .busy(busy), .done(done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a service "job" is a start cycle s; pin high for
   // cycles [s, s+PT*DIV), busy for [s, s+(PT+ST)*DIV), done on the cycle after.
   int              m_cur [NCH];
   int              m_tgt [NCH];
   int              m_ptr, m_cyc, m_ch, m_s;
   bit              m_job, m_dir, m_valid = 1'b0;
   logic [NCH-1:0]  e_up, e_down;
   int              e_step, e_rd;
   bit              e_busy, e_done;

   task automatic model_step();
      int c, n, idx;
      bit tk;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_cur[i] = 0;
            m_tgt[i] = 0;
         end
         m_ptr = NCH - 1; m_cyc = 0; m_job = 1'b0; m_valid = 1'b1;
         e_up = '0; e_down = '0; e_step = 0; e_rd = 0; e_busy = 1'b0; e_done = 1'b0;
         return;
      end
      if (!m_valid) return;
      c  = m_cyc;
      n  = c + 1;
      tk = ((c % DIV) == DIV - 1);
      e_rd   = m_cur[tgt_ch];
      e_step = (n / DIV) % 4;
      e_done = 1'b0;
      e_up   = '0;
      e_down = '0;
      if (m_job) begin
         if (n == m_s + PT*DIV) m_cur[m_ch] += m_dir ? 1 : -1;
         if (n == m_s + (PT+ST)*DIV) begin
            e_done = (m_cur[m_ch] == m_tgt[m_ch]);
            m_job  = 1'b0;
         end
      end else if (man_en) begin
         e_up   = man_up & ~man_down;
         e_down = man_down & ~man_up;
      end else if (tk) begin
         for (int k = 1; k <= NCH; k++) begin
            idx = (m_ptr + k) % NCH;
            if (m_cur[idx] != m_tgt[idx]) begin
               m_job = 1'b1; m_ch = idx; m_ptr = idx; m_s = n;
               m_dir = (m_tgt[idx] > m_cur[idx]);
               break;
            end
         end
      end
      if (m_job && n < m_s + PT*DIV) begin
         if (m_dir) e_up[m_ch] = 1'b1;
         else       e_down[m_ch] = 1'b1;
      end
      e_busy = m_job;
      if (tgt_wr) m_tgt[tgt_ch] = (int'(tgt_gain) > MAXG) ? MAXG : int'(tgt_gain);
      m_cyc = n;
   endtask

   function automatic bit model_settled();
      if (m_job) return 1'b0;
      for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) return 1'b0;
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge clk_1M);
      model_step();
   end

   // Pulse log (code = ch*2 + dir), widths, minimum low gap, done count.
   int              pl_code[$];
   int              pl_w[$];
   int              exp_q[$];
   int              min_gap, gapcnt, wcnt, dn_cnt;
   bit              gap_on;
   logic [NCH-1:0]  prev_ap = '0;
   int              fail_prints = 0;

   initial forever begin
      logic [NCH-1:0] ap;
      int ci;
      @(negedge clk_1M);
      if (m_valid) begin
         n_tests++;
         if (up !== e_up || down !== e_down || step !== 2'(e_step) || busy !== e_busy ||
             done !== e_done || rd_gain !== GW'(e_rd)) begin
            n_fail++;
            if (fail_prints < 40) begin
               fail_prints++;
               $display("FAIL cycle_cmp t=%0t got up=%b down=%b step=%0d busy=%0d done=%0d rd=%0d required up=%b down=%b step=%0d busy=%0d done=%0d rd=%0d",
                        $time, up, down, step, busy, done, rd_gain,
                        e_up, e_down, e_step, e_busy, e_done, e_rd);
            end
         end
      end
      ap = busy ? (up | down) : '0;
      if (ap != 0 && prev_ap == 0) begin
         ci = 0;
         for (int i = 0; i < NCH; i++) if (ap[i]) ci = i;
         pl_code.push_back(ci*2 + ((up != 0) ? 1 : 0));
         wcnt = 1;
         if (gap_on && gapcnt < min_gap) min_gap = gapcnt;
      end else if (ap != 0) begin
         wcnt++;
      end else if (prev_ap != 0) begin
         pl_w.push_back(wcnt);
         gap_on = 1'b1;
         gapcnt = 1;
      end else begin
         gapcnt++;
      end
      prev_ap = ap;
      if (done === 1'b1) dn_cnt++;
   end

   task automatic chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk_1M);
      #2;
   endtask

   task automatic wr(int ch, int g);
      tgt_wr = 1'b1; tgt_ch = 2'(ch); tgt_gain = GW'(g);
      cyc(1);
      tgt_wr = 1'b0;
   endtask

   task automatic clear_log();
      pl_code.delete(); pl_w.delete();
      min_gap = 1000; gap_on = 1'b0; gapcnt = 0; dn_cnt = 0;
   endtask

   task automatic wait_quiet(string nm, int budget);
      int k = 0;
      while ((busy || !model_settled()) && k < budget) begin
         cyc(1);
         k++;
      end
      chk({nm, "_settle_in_budget"}, int'(k < budget), 1);
      cyc(2);
   endtask

   task automatic chk_log(string nm, int width);
      chk({nm, "_pulse_count"}, pl_code.size(), exp_q.size());
      for (int i = 0; i < pl_code.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_pulse%0d_code", nm, i), pl_code[i], exp_q[i]);
      for (int i = 0; i < pl_w.size(); i++)
         chk($sformatf("%s_pulse%0d_width", nm, i), pl_w[i], width);
   endtask

   task automatic read_gain(string nm, int ch, int exp);
      tgt_ch = 2'(ch);
      cyc(1);
      chk(nm, int'(rd_gain), exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; tgt_wr = 1'b0; tgt_ch = '0; tgt_gain = '0;
      man_en = 1'b0; man_up = '0; man_down = '0;
      clear_log();
      cyc(3);
      chk("reset_up", int'(up), 0);
      chk("reset_step", int'(step), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;

      // Reset in the middle of a pulse
      wr(2, 2);
      k = 0;
      while ((up | down) == 0 && k < 100) begin cyc(1); k++; end
      chk("midpulse_pin_seen", int'(k < 100), 1);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      chk("midpulse_rst_up", int'(up), 0);
      chk("midpulse_rst_down", int'(down), 0);
      chk("midpulse_rst_step", int'(step), 0);
      chk("midpulse_rst_busy", int'(busy), 0);
      cyc(2);
      rst = 1'b0;
      for (int ch = 0; ch < NCH; ch++) read_gain($sformatf("midpulse_rd_ch%0d", ch), ch, 0);
      $display("[TB] reset mid-pulse: pins cleared, all gains read back");

      // Single ramp to 3 on channel 1
      clear_log();
      wr(1, 3);
      wait_quiet("ramp", 400);
      exp_q = '{3, 3, 3};
      chk_log("ramp", 8);
      chk("ramp_gap_ge4", int'(min_gap >= 4), 1);
      chk("ramp_done_count", dn_cnt, 1);
      read_gain("ramp_rd_ch1", 1, 3);
      $display("[TB] ramp ch1: pulses=%0d min_gap=%0d done=%0d", pl_code.size(), min_gap, dn_cnt);

      // Clamp then step down on channel 2
      clear_log();
      wr(2, 9);
      wait_quiet("clamp", 600);
      exp_q = '{5, 5, 5, 5, 5};
      chk_log("clamp", 8);
      read_gain("clamp_rd_ch2", 2, 5);
      clear_log();
      wr(2, 3);
      wait_quiet("down", 400);
      exp_q = '{4, 4};
      chk_log("down", 8);
      read_gain("down_rd_ch2", 2, 3);
      $display("[TB] clamp/down ch2: final pulses=%0d", pl_code.size());

      // Round robin after a fresh reset
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      clear_log();
      wr(0, 2);
      wr(3, 2);
      wait_quiet("rr", 600);
      exp_q = '{1, 7, 1, 7};
      chk_log("rr", 8);
      chk("rr_done_count", dn_cnt, 2);
      $display("[TB] round robin: pulses=%0d done=%0d", pl_code.size(), dn_cnt);

      // Retarget during the second up pulse
      clear_log();
      wr(1, 4);
      k = 0;
      while (pl_code.size() < 2 && k < 200) begin cyc(1); k++; end
      chk("retarget_second_pulse_seen", int'(k < 200), 1);
      wr(1, 0);
      wait_quiet("retarget", 600);
      exp_q = '{3, 3, 2, 2};
      chk_log("retarget", 8);
      chk("retarget_done_count", dn_cnt, 1);
      read_gain("retarget_rd_ch1", 1, 0);
      $display("[TB] retarget ch1: pulses=%0d done=%0d", pl_code.size(), dn_cnt);

      // Manual override
      man_up = 4'b0011; man_down = 4'b0110; man_en = 1'b1;
      cyc(1);
      chk("manual_up", int'(up), 4'b0001);
      chk("manual_down", int'(down), 4'b0100);
      wr(0, 1);
      cyc(20);
      chk("manual_busy_held", int'(busy), 0);
      chk("manual_up_held", int'(up), 4'b0001);
      read_gain("manual_rd_ch0", 0, 2);
      clear_log();
      man_en = 1'b0;
      cyc(1);
      chk("manual_release_up", int'(up), 0);
      wait_quiet("manual_resume", 400);
      exp_q = '{0};
      chk_log("manual_resume", 8);
      read_gain("manual_resume_rd_ch0", 0, 1);
      $display("[TB] manual: override held, auto resumed with %0d pulse(s)", pl_code.size());

      // Randomized soak
      for (int i = 0; i < 3000; i++) begin
         tgt_ch = 2'($urandom_range(0, NCH-1));
         if ($urandom_range(0, 29) == 0) begin
            tgt_wr = 1'b1;
            tgt_gain = GW'($urandom_range(0, 15));
         end else begin
            tgt_wr = 1'b0;
         end
         if ($urandom_range(0, 149) == 0) man_en = ~man_en;
         man_up   = NCH'($urandom);
         man_down = NCH'($urandom);
         rst = ($urandom_range(0, 999) == 0);
         cyc(1);
      end
      tgt_wr = 1'b0; rst = 1'b0; man_en = 1'b0;
      wait_quiet("random_drain", 2000);
      $display("[TB] random soak: 3000 cycles driven");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
